// File: rtl/iob_vexriscv_bus_bridge.sv
// VexRiscv cmd/rsp stream to IOb native bus bridge: registers commands, expands
// refill reads into bursts with several beats in flight, acks writes, remaps the MSB.
module iob_vexriscv_bus_bridge #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_BURST       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int REMAP_MSB       = 1,
  localparam int WORD_B         = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              boot_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [WORD_B-1:0] cmd_mask_i,
  input  logic [2:0]        cmd_size_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_last_o,
  output logic              iob_avalid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0] iob_wdata_o,
  output logic [WORD_B-1:0] iob_wstrb_o,
  input  logic              iob_ready_i,
  input  logic              iob_rvalid_i,
  input  logic [DATA_W-1:0] iob_rdata_i
);
  localparam int LOG_WB = $clog2(WORD_B);
  localparam int LOG_MB = $clog2(MAX_BURST);
  localparam int BEAT_W = LOG_MB + 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_OUT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  logic [0:0]        r_state;
  logic              r_up;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [WORD_B-1:0] r_wstrb;
  logic              r_wr;
  logic [BEAT_W-1:0] r_rem;
  logic [CNT_W-1:0]  r_out;
  logic [CNT_W-1:0]  r_fcnt;
  logic [PTR_W-1:0]  r_wp, r_rp;
  logic [BEAT_W-1:0] r_fifo [MAX_OUTSTANDING];
  logic [BEAT_W-1:0] r_bcnt;
  logic              r_rsp_valid, r_rsp_last;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_full, w_empty, w_cmd_hs, w_avalid, w_beat_hs, w_rd_beat;
  logic              w_rv, w_rlast, w_push, w_pop, w_msb;
  logic [2:0]        w_sh, w_lg;
  logic [BEAT_W-1:0] w_beats;
  logic [ADDR_W-1:0] w_amask;

  // Beat count and line alignment of the incoming command; oversize reads clamp to MAX_BURST.
  always_comb begin
    w_sh = cmd_size_i - 3'(LOG_WB);
    w_lg = '0;
    if (!cmd_wr_i && (cmd_size_i > 3'(LOG_WB)))
      w_lg = (w_sh > 3'(LOG_MB)) ? 3'(LOG_MB) : w_sh;
    w_beats = BEAT_W'(1) << w_lg;
    w_amask = cmd_wr_i ? '1 : ~((ADDR_W'(WORD_B) << w_lg) - ADDR_W'(1));
  end

  assign w_full      = (r_fcnt == MAX_OUT);
  assign w_empty     = (r_fcnt == '0);
  // Writes wait for a fully drained read path so their ack cannot collide with read data.
  assign cmd_ready_o = r_up & cke_i & (r_state == S_IDLE) & ~w_full &
                       (~cmd_wr_i | (w_empty & (r_out == '0)));
  assign w_cmd_hs    = cmd_valid_i & cmd_ready_o;
  assign w_avalid    = cke_i & (r_state == S_ISSUE) & (r_rem != '0) & (r_wr | (r_out < MAX_OUT));
  assign w_beat_hs   = w_avalid & iob_ready_i;
  assign w_rd_beat   = w_beat_hs & ~r_wr;
  assign w_rv        = cke_i & iob_rvalid_i & (r_out != '0);
  assign w_rlast     = ((r_bcnt + BEAT_W'(1)) == r_fifo[r_rp]);
  assign w_push      = w_cmd_hs & ~cmd_wr_i;
  assign w_pop       = w_rv & w_rlast;
  assign w_msb       = (REMAP_MSB != 0) ? ~boot_i : r_addr[ADDR_W-1];

  assign iob_avalid_o = w_avalid;
  assign iob_addr_o   = w_avalid ? {w_msb, r_addr[ADDR_W-2:0]} : '0;
  assign iob_wdata_o  = w_avalid ? r_wdata : '0;
  assign iob_wstrb_o  = w_avalid ? r_wstrb : '0;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_last_o   = r_rsp_last;
  assign rsp_data_o   = r_rsp_data;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state     <= S_IDLE;
      r_up        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wr        <= 1'b0;
      r_rem       <= '0;
      r_out       <= '0;
      r_fcnt      <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_bcnt      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
    end else if (cke_i) begin
      r_up <= 1'b1;
      case (r_state)
        S_IDLE: if (w_cmd_hs) begin
          r_addr  <= cmd_addr_i & w_amask;
          r_wdata <= cmd_data_i;
          r_wstrb <= cmd_wr_i ? cmd_mask_i : '0;
          r_wr    <= cmd_wr_i;
          r_rem   <= w_beats;
          r_state <= S_ISSUE;
        end
        default: if (w_beat_hs) begin
          r_rem  <= r_rem - BEAT_W'(1);
          r_addr <= r_addr + ADDR_W'(WORD_B);
          if (r_rem == BEAT_W'(1)) r_state <= S_IDLE;
        end
      endcase

      if (w_rd_beat && !w_rv)      r_out <= r_out + CNT_W'(1);
      else if (!w_rd_beat && w_rv) r_out <= r_out - CNT_W'(1);

      // Burst-length FIFO: one entry per read command, popped by its last data beat.
      if (w_push) begin
        r_fifo[r_wp] <= w_beats;
        r_wp         <= (r_wp == LAST_PTR) ? '0 : r_wp + PTR_W'(1);
      end
      if (w_pop) r_rp <= (r_rp == LAST_PTR) ? '0 : r_rp + PTR_W'(1);
      if (w_push && !w_pop)      r_fcnt <= r_fcnt + CNT_W'(1);
      else if (!w_push && w_pop) r_fcnt <= r_fcnt - CNT_W'(1);

      if (w_rv) r_bcnt <= w_rlast ? '0 : r_bcnt + BEAT_W'(1);

      r_rsp_valid <= w_rv | (w_beat_hs & r_wr);
      r_rsp_last  <= (w_rv & w_rlast) | (w_beat_hs & r_wr);
      r_rsp_data  <= w_rv ? iob_rdata_i : '0;
    end
  end
endmodule

// File: tb/tb_iob_vexriscv_bus_bridge.sv
// Randomized bench: IOb slave model plus a transaction-level model of expected
// IOb requests and CPU responses, checked every cycle.
module tb_iob_vexriscv_bus_bridge;
  logic        clk = 1'b0, arst_n = 1'b0, cke = 1'b1, boot = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [3:0]  cmd_mask = '0;
  logic [2:0]  cmd_size = '0;
  logic        rsp_valid, rsp_last;
  logic [31:0] rsp_data;
  logic        iob_avalid;
  logic [31:0] iob_addr, iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready = 1'b0, iob_rvalid = 1'b0;
  logic [31:0] iob_rdata = '0;

  iob_vexriscv_bus_bridge dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .boot_i(boot),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask), .cmd_size_i(cmd_size),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
    .iob_avalid_o(iob_avalid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
    .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid),
    .iob_rdata_i(iob_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [3:0] s; logic [31:0] d; } req_t;
  typedef struct packed { logic [31:0] d; logic last; } rsp_t;
  typedef struct packed { logic [31:0] d; int t; } rd_t;

  int   nvec = 0, nerr = 0;
  req_t exp_req[$];
  rsp_t exp_rsp[$];
  rd_t  rq[$];
  int   rd_beats[$];
  int   n_out = 0, rv_cnt = 0, cyc = 0, max_out = 0;
  int   ready_mode = 0, rv_delay = 0;
  int   rsp_cnt = 0, last_cnt = 0, rd_hs_cnt = 0;
  bit   slave_en = 1'b1, exp_vld = 1'b0, prev_stall = 1'b0, cmd_hs = 1'b0;
  logic [31:0] prev_addr, prev_wdata, m_addr;
  logic [3:0]  prev_wstrb, m_wstrb;
  bit   m_avalid, m_cmd_ready, m_rsp_valid, m_rsp_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0000_0104) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A);
  endfunction

  function automatic logic [31:0] remap(input logic [31:0] a);
    return {~boot, a[30:0]};
  endfunction

  // Expected IOb beats and CPU responses for a command accepted this cycle.
  task automatic model_cmd();
    req_t q;
    rsp_t r;
    int beats;
    logic [31:0] base;
    if (cmd_wr) begin
      q.a = remap(cmd_addr); q.s = cmd_mask; q.d = cmd_data;
      exp_req.push_back(q);
      r.d = '0; r.last = 1'b1;
      exp_rsp.push_back(r);
    end else begin
      assert (cmd_size <= 3'd5) else $error("read burst exceeds MAX_BURST, size %0d", cmd_size);
      beats = (cmd_size > 3'd2) ? (1 << (cmd_size - 3'd2)) : 1;
      base  = cmd_addr & ~(32'(beats * 4 - 1));
      for (int i = 0; i < beats; i++) begin
        q.a = remap(base + 32'(4 * i)); q.s = '0; q.d = '0;
        exp_req.push_back(q);
        r.d = mem(q.a); r.last = (i == beats - 1);
        exp_rsp.push_back(r);
      end
      rd_beats.push_back(beats);
    end
  endtask

  task automatic monitor();
    rsp_t r;
    req_t q;
    rd_t  e;
    bit   iob_hs, rv_acc;
    int   pend;
    cmd_hs = 1'b0;
    if (!arst_n) begin
      exp_vld = 1'b0; prev_stall = 1'b0;
      return;
    end
    m_avalid = iob_avalid; m_addr = iob_addr; m_wstrb = iob_wstrb;
    m_cmd_ready = cmd_ready; m_rsp_valid = rsp_valid; m_rsp_last = rsp_last;

    chk("rsp_valid", rsp_valid, exp_vld);
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
      else begin
        r = exp_rsp.pop_front();
        chk("rsp_data", rsp_data, r.d);
        chk("rsp_last", rsp_last, r.last);
        rsp_cnt++;
        if (rsp_last) last_cnt++;
      end
    end
    if (prev_stall) begin
      chk("hold_avalid", iob_avalid, 1);
      chk("hold_addr", iob_addr, prev_addr);
      chk("hold_wstrb", iob_wstrb, prev_wstrb);
      chk("hold_wdata", iob_wdata, prev_wdata);
    end
    if (n_out >= 4) chk("out_cap", iob_avalid, 0);
    pend = rd_beats.size();
    if (exp_req.size() == 0) chk("cmd_ready", cmd_ready, (pend < 4) && (!cmd_wr || pend == 0));
    else chk("cmd_ready_busy", cmd_ready, 0);

    iob_hs = iob_avalid & iob_ready;
    if (iob_hs) begin
      if (exp_req.size() == 0) chk("iob_extra", 1, 0);
      else begin
        q = exp_req.pop_front();
        chk("iob_addr", iob_addr, q.a);
        chk("iob_wstrb", iob_wstrb, q.s);
        if (q.s != 0) chk("iob_wdata", iob_wdata, q.d);
      end
      if (iob_wstrb == 0) begin
        e.d = mem(iob_addr); e.t = cyc + 1 + rv_delay;
        rq.push_back(e);
        rd_hs_cnt++;
      end
    end
    rv_acc  = iob_rvalid && (n_out > 0);
    exp_vld = rv_acc || (iob_hs && iob_wstrb != 0);
    if (rv_acc) begin
      rv_cnt++;
      if (rd_beats.size() > 0 && rv_cnt == rd_beats[0]) begin
        void'(rd_beats.pop_front());
        rv_cnt = 0;
      end
    end
    n_out = n_out + ((iob_hs && iob_wstrb == 0) ? 1 : 0) - (rv_acc ? 1 : 0);
    if (n_out > max_out) max_out = n_out;
    prev_stall = iob_avalid & ~iob_ready;
    prev_addr = iob_addr; prev_wstrb = iob_wstrb; prev_wdata = iob_wdata;
    cmd_hs = cmd_valid & cmd_ready;
    if (cmd_hs) model_cmd();
  endtask

  // One clock: slave drives at negedge, outputs sampled just after, edge, then return.
  task automatic tick();
    @(negedge clk);
    if (slave_en) begin
      case (ready_mode)
        0:       iob_ready = 1'b1;
        1:       iob_ready = ($urandom_range(0, 3) != 0);
        default: iob_ready = 1'b0;
      endcase
      iob_rvalid = 1'b0;
      iob_rdata  = $urandom;
      if (rq.size() > 0 && rq[0].t <= cyc && (ready_mode != 1 || $urandom_range(0, 4) != 0)) begin
        iob_rvalid = 1'b1;
        iob_rdata  = rq[0].d;
        void'(rq.pop_front());
      end
    end
    #1;
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [2:0] s);
    bit ok = 1'b0;
    cmd_wr = wr; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_size = s;
    cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = cmd_hs;
    end
    if (!ok) chk("cmd_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && (exp_req.size() + exp_rsp.size() + rq.size()) != 0; i++) tick();
    if ((exp_req.size() + exp_rsp.size() + rq.size()) != 0) chk("idle_timeout", 0, 1);
  endtask

  task automatic release_rst();
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_req.delete(); exp_rsp.delete(); rq.delete(); rd_beats.delete();
    n_out = 0; rv_cnt = 0; exp_vld = 1'b0; prev_stall = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_avalid", iob_avalid, 0);
    chk("rst_rsp", {rsp_valid, rsp_last}, 0);
    chk("rst_addr", iob_addr, 0);
    chk("rst_wstrb", iob_wstrb, 0);
    release_rst();
    tick();
    chk("ready_after_rst", m_cmd_ready, 1);

    // Single word read, boot=1: command in N, request in N+1
    send_cmd(1'b0, 32'h0000_0104, '0, '0, 3'd2);
    tick();
    chk("rd_req_latency", m_avalid, 1);
    chk("rd_req_addr", m_addr, 32'h0000_0104);
    wait_idle();

    // Write held off by three ready-low cycles
    ready_mode = 2;
    send_cmd(1'b1, 32'h10, 32'h1122_3344, 4'h3, 3'd2);
    repeat (3) begin
      tick();
      chk("wr_stall_avalid", m_avalid, 1);
      chk("wr_stall_wstrb", m_wstrb, 4'h3);
    end
    ready_mode = 0;
    tick();
    tick();
    chk("wr_rsp", {m_rsp_valid, m_rsp_last}, 2'b11);
    chk("wr_next_ready", m_cmd_ready, 1);
    wait_idle();

    // Refill with random stalls
    rsp_cnt = 0; last_cnt = 0; ready_mode = 1; rv_delay = 0;
    send_cmd(1'b0, 32'h1004, '0, '0, 3'd5);
    wait_idle();
    chk("refill_beats", rsp_cnt, 8);
    chk("refill_lasts", last_cnt, 1);

    // Back-to-back refills against a slow slave
    rsp_cnt = 0; last_cnt = 0; ready_mode = 0; rv_delay = 6; max_out = 0;
    send_cmd(1'b0, 32'h2000, '0, '0, 3'd5);
    send_cmd(1'b0, 32'h2044, '0, '0, 3'd5);
    wait_idle();
    chk("b2b_beats", rsp_cnt, 16);
    chk("b2b_lasts", last_cnt, 2);
    chk("b2b_max_out", max_out, 4);

    // MSB remap with boot=0
    boot = 1'b0; rv_delay = 1;
    send_cmd(1'b0, 32'h0000_0040, '0, '0, 3'd2);
    tick();
    chk("remap_addr", m_addr, 32'h8000_0040);
    wait_idle();
    boot = 1'b1;

    // Random mix
    for (int k = 0; k < 80; k++) begin
      if (k % 10 == 0) begin
        wait_idle();
        boot = 1'($urandom_range(0, 1));
      end
      ready_mode = 1;
      rv_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0)
        send_cmd(1'b1, $urandom, $urandom, 4'($urandom_range(1, 15)), 3'd2);
      else
        send_cmd(1'b0, $urandom, '0, '0, 3'($urandom_range(0, 5)));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    boot = 1'b1;

    // Reset in the middle of a burst
    ready_mode = 0; rv_delay = 40; rd_hs_cnt = 0;
    send_cmd(1'b0, 32'h3008, '0, '0, 3'd5);
    for (int i = 0; i < 50 && rd_hs_cnt < 3; i++) tick();
    chk("beats_before_rst", rd_hs_cnt, 3);
    arst_n = 1'b0;
    #1;
    chk("midrst_avalid", iob_avalid, 0);
    chk("midrst_rsp", {rsp_valid, rsp_last}, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_addr", iob_addr, 0);
    clear_model();
    repeat (2) tick();
    release_rst();
    slave_en = 1'b0;
    iob_rvalid = 1'b1;
    iob_rdata = 32'hCAFE_F00D;
    tick();
    iob_rvalid = 1'b0;
    tick();
    chk("late_rvalid_ignored", m_rsp_valid, 0);
    slave_en = 1'b1; rv_delay = 0; rsp_cnt = 0; last_cnt = 0;
    send_cmd(1'b0, 32'h3100, '0, '0, 3'd3);
    wait_idle();
    chk("post_rst_beats", rsp_cnt, 2);
    chk("post_rst_lasts", last_cnt, 1);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/iob_vexriscv_bus_bridge.md
# iob_vexriscv_bus_bridge

Parametrised bridge between a VexRiscv-style command/response stream port (instruction or data bus) and the IOb native bus. It registers each accepted command, expands cache-line refill reads into multi-beat IOb read bursts, allows several read beats in flight, generates write acknowledges, and optionally remaps the address MSB from boot status. One instance sits on each CPU bus in front of the SoC interconnect.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (power of 2, ≥32); WORD_B = DATA_W/8
- MAX_BURST, 8, maximum beats per read command (power of 2)
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered IOb read beats; also the depth of the burst-length FIFO
- REMAP_MSB, 1, if 1 the IOb address MSB is replaced by ~boot_i

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  reset, asynchronous, active-low
- cke_i  in  1  clock enable; when 0 all state holds
- boot_i  in  1  boot status
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_wr_i  in  1  1 = write
- cmd_addr_i  in  ADDR_W  byte address
- cmd_data_i  in  DATA_W  write data
- cmd_mask_i  in  WORD_B  write byte mask
- cmd_size_i  in  3  log2 of transfer bytes
- rsp_valid_o  out  1  response beat
- rsp_data_o  out  DATA_W  read data
- rsp_last_o  out  1  final beat of command
- iob_avalid_o  out  1  IOb request valid
- iob_addr_o  out  ADDR_W  IOb address
- iob_wdata_o  out  DATA_W  IOb write data
- iob_wstrb_o  out  WORD_B  IOb write strobe (0 = read)
- iob_ready_i  in  1  IOb request accepted
- iob_rvalid_i  in  1  IOb read data valid
- iob_rdata_i  in  DATA_W  IOb read data

## Operation
- Beats per command: reads with cmd_size_i > log2(WORD_B) → 2^size/WORD_B; otherwise 1. Writes always 1 beat. Read beats > MAX_BURST is illegal (bench assertion); the block clamps to MAX_BURST.
- FSM: IDLE, ISSUE.
  - IDLE: cmd_ready_o = ~len_fifo_full & (~cmd_wr_i | (len_fifo_empty & outstanding==0)). On handshake, register addr (read: low log2(beats·WORD_B) bits cleared), data, strb (cmd_mask_i if write, else 0), beat count; push beat count into length FIFO for reads; go to ISSUE.
  - ISSUE: iob_avalid_o = 1 when beats remain and (write, or outstanding < MAX_OUTSTANDING). Payload is stable while avalid is high and ready is low. On avalid & ready: remaining−1, address += WORD_B, outstanding+1 for reads. After the last beat is accepted, go to IDLE.
- Address remap: iob_addr_o[ADDR_W-1] = ~boot_i if REMAP_MSB, else the registered bit. boot_i is sampled live.
- Outstanding counter: +1 on read beat accept, −1 on iob_rvalid_i. If both happen in the same cycle, the count is unchanged. iob_rvalid_i with outstanding==0 is ignored.
- Read response: rsp_valid_o/rsp_data_o are registered copies of iob_rvalid_i/iob_rdata_i. A beat counter compares against the FIFO head. rsp_last_o = 1 on the beat that equals the head; that beat pops the FIFO and clears the counter.
- Write response: the cycle after the IOb write handshake, rsp_valid_o = 1, rsp_last_o = 1, rsp_data_o = 0. Writes are only accepted with nothing in flight, so read and write responses never collide.
- Reset (arst_n_i low, any time): FSM → IDLE; counters, FIFO and all registers cleared; in-flight beats are discarded.

## Timing
- Reset values: cmd_ready_o 0 while reset is asserted, then 1 from the first cycle after release. All other outputs are 0.
- Command accepted in cycle N → iob_avalid_o high in N+1.
- iob_rvalid_i in cycle M → rsp_valid_o in M+1.
- Write handshake in cycle K → write rsp_valid_o in K+1. The next command can be accepted in K+1 at the earliest.
- Sustained burst throughput is 1 beat/cycle while iob_ready_i = 1 and rvalid keeps pace.

## Test plan
- Single read at 0x0000_0104, size 2, boot_i=1, REMAP_MSB=1 → one IOb read at 0x0000_0104; rdata 0xDEADBEEF → rsp_valid=1, rsp_data=0xDEADBEEF, rsp_last=1 one cycle later.
- Write at 0x10, data 0x11223344, mask 0x3 → iob_wstrb=0x3 held through 3 cycles of iob_ready_i=0; single rsp with last=1 the cycle after the handshake.
- Refill read at 0x1004, size 5 → 8 beats at 0x1000…0x101C with random ready stalls; 8 responses with rsp_last only on the 8th.
- Two back-to-back size-5 reads with rvalid delayed 6 cycles → avalid drops once outstanding=4; rsp_last on beats 8 and 16; the FIFO never overflows.
- boot_i=0 read at 0x0000_0040 → iob_addr_o=0x8000_0040.
- arst_n_i low mid-burst (after beat 3) → outputs 0 immediately; a late rvalid is ignored; a new read after release completes normally.
